ahb_fifo_read_streamer: RTL and testbench

Parametrised JTAG data-register back end that drains the AHB read FIFO onto TDO as a continuous stream of framed words during a single DR scan. It is the successor to the single-word AHB FIFO read shifter. It adds configurable data width, multi-word bursts per scan with a burst cap, a per-frame valid flag, and a non-destructive peek mode. It sits between the TAP controller's DR control strobes and the read side of the AHB-to-JTAG async FIFO (first-word-fall-through).

---
 rtl/jtag_types_pkg.sv | 9 +
 rtl/ahb_fifo_read_streamer_if.sv | 34 +++
 rtl/frame_shifter.sv | 37 +++
 rtl/ahb_fifo_read_streamer.sv | 85 ++++++++
 tb/tb_ahb_fifo_read_streamer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/jtag_types_pkg.sv
// Shared JTAG back-end types: state encoding for the AHB FIFO read streamer.
package jtag_types_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ahb_rd_state_t;

endpackage

// File: rtl/ahb_fifo_read_streamer_if.sv
// Bundle of TAP strobes, FIFO read side and serial output for the read streamer.
interface ahb_fifo_read_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic TCK
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic                  tlr_reset;
    logic                  ahb_fifo_read_select;
    logic                  dr_capture;
    logic                  dr_shift;
    logic                  dr_update;
    logic                  peek;
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  TDO;
    logic                  rinc;
    logic [CNT_W-1:0]      words_read;

    modport DUT (
        input  TCK, tlr_reset, ahb_fifo_read_select, dr_capture, dr_shift,
               dr_update, peek, empty, rdata,
        output TDO, rinc, words_read
    );

    modport TB (
        input  TCK, TDO, rinc, words_read,
        output tlr_reset, ahb_fifo_read_select, dr_capture, dr_shift,
               dr_update, peek, empty, rdata
    );

endinterface

// File: rtl/frame_shifter.sv
// Frame shift register with parallel load, LSB-first shift, hold and a bit
// counter that flags the last bit of the frame.
module frame_shifter #(
    parameter int FRAME_W = 9
) (
    input  logic               TCK,
    input  logic               tlr_reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_value,
    input  logic               shift_en,
    output logic               lsb,
    output logic               boundary
);
    localparam int BC_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] sr;
    logic [BC_W-1:0]    bit_cnt;

    // Load takes priority over shift; with neither, the frame holds (Pause-DR).
    always_ff @(posedge TCK) begin
        if (tlr_reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= load_value;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sr      <= sr >> 1;
            bit_cnt <= bit_cnt + BC_W'(1);
        end
    end

    assign lsb      = sr[0];
    assign boundary = (bit_cnt == LAST_BIT);

endmodule

// File: rtl/ahb_fifo_read_streamer.sv
// JTAG DR back end that streams framed FIFO words ({data, valid}, LSB first)
// onto TDO during one DR scan, with a per-scan burst cap and a peek mode.
module ahb_fifo_read_streamer
    import jtag_types_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int FRAME_W    = DATA_WIDTH + 1,
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                  TCK,
    input  logic                  tlr_reset,
    input  logic                  ahb_fifo_read_select,
    input  logic                  dr_capture,
    input  logic                  dr_shift,
    input  logic                  dr_update,
    input  logic                  peek,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  TDO,
    output logic                  rinc,
    output logic [CNT_W-1:0]      words_read
);
    localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

    ahb_rd_state_t      state;
    logic               capture_load;
    logic               boundary_load;
    logic               load;
    logic               burst_open;
    logic               can_read;
    logic               shift_en;
    logic               boundary;
    logic               sr_lsb;
    logic [FRAME_W-1:0] load_value;

    assign capture_load  = ahb_fifo_read_select & dr_capture;
    assign boundary_load = (state == SHIFT) & ahb_fifo_read_select & dr_shift & boundary;
    assign load          = capture_load | boundary_load;

    // A capture starts a fresh burst, so the count left over from the last scan is ignored.
    assign burst_open = capture_load | (words_read < BURST_CAP);
    assign can_read   = ~empty & burst_open;
    assign load_value = can_read ? {rdata, 1'b1} : '0;

    assign rinc     = load & can_read & ~peek & ~tlr_reset;
    assign shift_en = (state == SHIFT) & ahb_fifo_read_select & dr_shift
                      & ~boundary & ~capture_load;
    assign TDO      = (state == SHIFT) & ahb_fifo_read_select & sr_lsb;

    frame_shifter #(
        .FRAME_W(FRAME_W)
    ) u_frame_shifter (
        .TCK       (TCK),
        .tlr_reset (tlr_reset),
        .load      (load),
        .load_value(load_value),
        .shift_en  (shift_en),
        .lsb       (sr_lsb),
        .boundary  (boundary)
    );

    // Capture beats update when both arrive together.
    always_ff @(posedge TCK) begin
        if (tlr_reset) begin
            state <= IDLE;
        end else if (capture_load) begin
            state <= SHIFT;
        end else if ((state == SHIFT) && (dr_update || !ahb_fifo_read_select)) begin
            state <= IDLE;
        end
    end

    // Every valid load counts, popped or peeked, so the cap holds in both modes.
    always_ff @(posedge TCK) begin
        if (tlr_reset) begin
            words_read <= '0;
        end else if (capture_load) begin
            words_read <= can_read ? CNT_W'(1) : '0;
        end else if (boundary_load && can_read) begin
            words_read <= words_read + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahb_fifo_read_streamer.sv
// Scoreboard bench for ahb_fifo_read_streamer: expected TDO frames are queued as
// scans are started and compared bit by bit as the DUT shifts them out.
module tb_ahb_fifo_read_streamer;

    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int CNT_W      = $clog2(MAX_BURST + 1);

    logic TCK = 1'b0;
    always #5 TCK = ~TCK;

    ahb_fifo_read_streamer_if #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) bus (
        .TCK(TCK)
    );

    ahb_fifo_read_streamer #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .TCK                 (TCK),
        .tlr_reset           (bus.tlr_reset),
        .ahb_fifo_read_select(bus.ahb_fifo_read_select),
        .dr_capture          (bus.dr_capture),
        .dr_shift            (bus.dr_shift),
        .dr_update           (bus.dr_update),
        .peek                (bus.peek),
        .empty               (bus.empty),
        .rdata               (bus.rdata),
        .TDO                 (bus.TDO),
        .rinc                (bus.rinc),
        .words_read          (bus.words_read)
    );

    logic [DATA_WIDTH-1:0] fifo[$];
    logic                  exp_q[$];
    int                    checks = 0;
    int                    errors = 0;
    int                    pops   = 0;
    logic                  peek_mode = 1'b0;
    logic                  tdo_s;
    logic                  rinc_s;
    logic [CNT_W-1:0]      wr_s;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One TCK cycle: drive at negedge, sample just after, retire any pop at the posedge.
    task automatic applyStimulus(input logic rst, input logic cap, input logic sh,
                                 input logic upd, input logic sel);
        @(negedge TCK);
        bus.tlr_reset            = rst;
        bus.dr_capture           = cap;
        bus.dr_shift             = sh;
        bus.dr_update            = upd;
        bus.ahb_fifo_read_select = sel;
        bus.peek                 = peek_mode;
        bus.empty                = (fifo.size() == 0);
        bus.rdata                = (fifo.size() == 0) ? '0 : fifo[0];
        #1;
        tdo_s  = bus.TDO;
        rinc_s = bus.rinc;
        wr_s   = bus.words_read;
        @(posedge TCK);
        if (rinc_s) begin
            pops++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
    endtask

    task automatic push_frame(input logic valid, input logic [DATA_WIDTH-1:0] data);
        exp_q.push_back(valid);
        for (int i = 0; i < DATA_WIDTH; i++) exp_q.push_back(data[i]);
    endtask

    task automatic shift_bits(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (exp_q.size() == 0) checkOutput({tag, "_scoreboard_underflow"}, 32'd1, 32'd0);
            else checkOutput(tag, {31'd0, tdo_s}, {31'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_reset(input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_rst_tdo"},  {31'd0, tdo_s},  32'd0);
        checkOutput({tag, "_rst_rinc"}, {31'd0, rinc_s}, 32'd0);
        checkOutput({tag, "_rst_wr"},   32'(wr_s),       32'd0);
        exp_q.delete();
        fifo.delete();
        pops      = 0;
        peek_mode = 1'b0;
    endtask

    initial begin
        bus.tlr_reset            = 1'b1;
        bus.dr_capture           = 1'b0;
        bus.dr_shift             = 1'b0;
        bus.dr_update            = 1'b0;
        bus.ahb_fifo_read_select = 1'b0;
        bus.peek                 = 1'b0;
        bus.empty                = 1'b1;
        bus.rdata                = '0;

        // Single word 0xA5: one pop at capture.
        do_reset("t1");
        fifo.push_back(8'hA5);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_rinc_capture", {31'd0, rinc_s}, 32'd1);
        push_frame(1'b1, 8'hA5);
        shift_bits(9, "t1_tdo");
        checkOutput("t1_words_read", 32'(wr_s), 32'd1);
        checkOutput("t1_pops", pops, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Five words queued, burst capped at four.
        do_reset("t2");
        for (int i = 1; i <= 5; i++) fifo.push_back(8'(i));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) push_frame(1'b1, 8'(i));
        push_frame(1'b0, 8'h00);
        shift_bits(45, "t2_tdo");
        checkOutput("t2_pops", pops, 32'd4);
        checkOutput("t2_fifo_left", fifo.size(), 32'd1);
        if (fifo.size() > 0) checkOutput("t2_fifo_head", 32'(fifo[0]), 32'h05);
        checkOutput("t2_words_read", 32'(wr_s), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Empty at capture, word arrives mid-frame and appears only at the boundary.
        do_reset("t3");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_rinc_capture", {31'd0, rinc_s}, 32'd0);
        push_frame(1'b0, 8'h00);
        shift_bits(4, "t3_tdo_empty");
        fifo.push_back(8'h3C);
        push_frame(1'b1, 8'h3C);
        shift_bits(5, "t3_tdo_empty");
        checkOutput("t3_rinc_boundary", {31'd0, rinc_s}, 32'd1);
        shift_bits(9, "t3_tdo_word");
        checkOutput("t3_pops", pops, 32'd1);
        checkOutput("t3_words_read", 32'(wr_s), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Peek: same head repeated up to the cap, nothing popped.
        do_reset("t4");
        peek_mode = 1'b1;
        fifo.push_back(8'h7E);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_rinc_capture", {31'd0, rinc_s}, 32'd0);
        for (int i = 0; i < MAX_BURST; i++) push_frame(1'b1, 8'h7E);
        push_frame(1'b0, 8'h00);
        shift_bits(45, "t4_tdo");
        checkOutput("t4_pops", pops, 32'd0);
        checkOutput("t4_fifo_left", fifo.size(), 32'd1);
        checkOutput("t4_words_read", 32'(wr_s), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Pause-DR in the middle of a frame.
        do_reset("t5");
        fifo.push_back(8'h96);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        push_frame(1'b1, 8'h96);
        shift_bits(4, "t5_tdo_pre");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("t5_tdo_pause", {31'd0, tdo_s}, {31'd0, exp_q[0]});
        end
        shift_bits(5, "t5_tdo_post");
        checkOutput("t5_pops", pops, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-frame, then reset coincident with capture.
        do_reset("t6");
        fifo.push_back(8'h11);
        fifo.push_back(8'h22);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        push_frame(1'b1, 8'h11);
        shift_bits(5, "t6_tdo");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_rinc_in_reset", {31'd0, rinc_s}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_tdo_after_reset", {31'd0, tdo_s}, 32'd0);
        checkOutput("t6_rinc_after_reset", {31'd0, rinc_s}, 32'd0);
        checkOutput("t6_wr_after_reset", 32'(wr_s), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_rinc_reset_capture", {31'd0, rinc_s}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_tdo_reset_capture", {31'd0, tdo_s}, 32'd0);
        checkOutput("t6_wr_reset_capture", 32'(wr_s), 32'd0);
        checkOutput("t6_pops", pops, 32'd1);
        checkOutput("t6_fifo_left", fifo.size(), 32'd1);
        exp_q.delete();

        // Capture and update together: capture wins.
        do_reset("t7");
        fifo.push_back(8'h5A);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("t7_rinc_capture", {31'd0, rinc_s}, 32'd1);
        push_frame(1'b1, 8'h5A);
        shift_bits(9, "t7_tdo");
        checkOutput("t7_pops", pops, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
